led_scroll_buffer: RTL and testbench
====================================

Name: led_scroll_buffer

Overview:
- Column-pattern store and scroller sitting directly upstream of the 4-column x 8-line LED matrix driver.
- Accepts a message of up to DEPTH 8-bit column patterns over a valid/ready byte stream.
- Then presents a sliding 4-column window of that message on l1..l4, advancing one column every STEP_DIV clocks, wrapping circularly.

Parameters:
DEPTH, 16, max message length in columns (power of two, >=4)
ADDR_W, 4, clog2(DEPTH)
STEP_DIV, 1200000, clocks per scroll step (100 ms at 12 MHz); >=2

Ports:
clk12MHz  in  1  system clock
rst  in  1  synchronous active-high reset
wr_valid  in  1  column byte offered
wr_ready  out  1  block accepts byte this cycle
wr_data  in  8  column pattern, bit n = line n
wr_last  in  1  qualifies final byte of message
clear  in  1  one-cycle pulse: discard message, return to IDLE
run  in  1  level: 1 = scroll, 0 = freeze window
l1  out  8  window column 0 (registered)
l2  out  8  window column 1
l3  out  8  window column 2
l4  out  8  window column 3
offset  out  ADDR_W  index of message column shown on l1
wrap_pulse  out  1  one-cycle strobe when offset wraps to 0
showing  out  1  high in SHOW state

Behaviour:
- Clocking and reset:
  - Single clock, all state on posedge clk12MHz.
  - rst (synchronous, active-high) forces: state=IDLE, wr_ptr=0, len=0, offset=0, step_cnt=0, l1..l4=0, wrap_pulse=0, showing=0.
  - RAM contents are not cleared.
- States: IDLE (empty), LOAD (partial message), SHOW (displaying).
- Write handshake:
  - wr_ready = (state!=SHOW) && !clear; this is the only combinational output.
  - A beat transfers when wr_valid && wr_ready. It writes mem[wr_ptr], then wr_ptr++.
  - IDLE -> LOAD on the first accepted beat without wr_last.
  - Accepted beat with wr_last, or with wr_ptr==DEPTH-1 (forced last; overflow is impossible): len<=wr_ptr+1, offset<=0, step_cnt<=0, state<=SHOW. This applies from IDLE or LOAD, so a 1-byte message goes IDLE->SHOW.
- clear:
  - In any state, clear -> IDLE next cycle, wr_ptr=0, len=0, offset=0, l1..l4=0.
  - clear has priority over a simultaneous write; that write is not accepted.
- SHOW window:
  - Index chain: idx0=offset, idxk = (idx(k-1)+1==len) ? 0 : idx(k-1)+1.
  - l(k+1) <= mem[idxk] every cycle, one-cycle latency from offset/RAM change.
  - First window visible the cycle after entering SHOW.
  - len<4 repeats columns circularly. Example: len=2, offset=0 gives A,B,A,B.
- Scrolling:
  - In SHOW with run=1: step_cnt counts 0..STEP_DIV-1.
  - At terminal count: step_cnt<=0, offset <= (offset+1==len) ? 0 : offset+1.
  - wrap_pulse=1 for exactly the cycle offset becomes 0 by wrap; never on SHOW entry.
  - len=1: offset stays 0 and wrap_pulse fires every step.
  - run=0 holds step_cnt and offset; window stays frozen; resuming continues the count.
- Outside SHOW: l1..l4=0, offset=0, step_cnt=0, wrap_pulse=0.
- showing = registered (state==SHOW).
- Reset or clear mid-LOAD discards the partial message; mid-SHOW it blanks l1..l4 the next cycle.

Decomposition:
- Shared package led_pkg: NUM_COLS=4, ROW_W=8, state encoding (IDLE=0, LOAD=1, SHOW=2).
- The matrix driver consumes NUM_COLS/ROW_W from the same package.
- One sub-module, led_col_ram: DEPTH x ROW_W, synchronous write, four asynchronous read ports (idx0..idx3). Maps to LUT RAM.

Test Plan:
- Reset, then load 6 bytes 01,02,04,08,10,20 (wr_last on 6th), run=1, STEP_DIV=4 -> first window 01,02,04,08; after 4 clks offset=1 shows 02,04,08,10; offset=5 shows 20,01,02,04; wrap_pulse exactly once at 24 clks after SHOW entry.
- Load 2 bytes AA,55 -> window AA,55,AA,55; one step later 55,AA,55,AA with wrap_pulse on the following step.
- Stream 20 bytes with wr_last never set -> 16 accepted, SHOW entered after 16th, wr_ready=0 for beats 17-20, len=16.
- SHOW, run=0 for 10 clks mid-count -> offset and l1..l4 unchanged; run=1 resumes the step at the remaining count.
- clear asserted with wr_valid in LOAD -> beat not accepted, IDLE, l1..l4=00, next message loads from address 0.
- rst pulsed in SHOW at offset=3 -> next cycle l1..l4=00, showing=0, wr_ready=1.

Source files
------------

// File: rtl/led_pkg.sv
// Shared definitions for the LED matrix path: column geometry and the
// scroll-buffer state encoding. The matrix driver imports the same geometry.
package led_pkg;

  localparam int NUM_COLS = 4;
  localparam int ROW_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SHOW = 2'd2
  } state_t;

endpackage

// File: rtl/led_col_ram.sv
// Column pattern store: DEPTH x ROW_W, one synchronous write port and four
// asynchronous read ports, so that a whole display window is read each cycle.
module led_col_ram
  import led_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk12MHz,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [ROW_W-1:0]  wdata,
  input  logic [ADDR_W-1:0] idx0,
  input  logic [ADDR_W-1:0] idx1,
  input  logic [ADDR_W-1:0] idx2,
  input  logic [ADDR_W-1:0] idx3,
  output logic [ROW_W-1:0]  col0,
  output logic [ROW_W-1:0]  col1,
  output logic [ROW_W-1:0]  col2,
  output logic [ROW_W-1:0]  col3
);

  logic [ROW_W-1:0] mem [DEPTH];

  // Write port; contents are deliberately left uninitialised by reset.
  always_ff @(posedge clk12MHz) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign col0 = mem[idx0];
  assign col1 = mem[idx1];
  assign col2 = mem[idx2];
  assign col3 = mem[idx3];

endmodule

// File: rtl/led_scroll_buffer.sv
// Column-pattern store and scroller feeding the 4x8 LED matrix driver.
// A message of up to DEPTH column bytes is loaded over a valid/ready stream,
// then a 4-column window slides over it circularly, one column per STEP_DIV
// clocks while run is high.
module led_scroll_buffer
  import led_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int STEP_DIV = 1200000
) (
  input  logic              clk12MHz,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [7:0]        wr_data,
  input  logic              wr_last,
  input  logic              clear,
  input  logic              run,
  output logic [7:0]        l1,
  output logic [7:0]        l2,
  output logic [7:0]        l3,
  output logic [7:0]        l4,
  output logic [ADDR_W-1:0] offset,
  output logic              wrap_pulse,
  output logic              showing
);

  localparam int                CNT_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STEP_DIV - 1);
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

  // Circular successor of a column index inside a message of n columns.
  function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] i,
                                                  input logic [ADDR_W:0]   n);
    logic [ADDR_W:0] s;
    s = {1'b0, i} + (ADDR_W+1)'(1);
    return (s == n) ? '0 : s[ADDR_W-1:0];
  endfunction

  state_t            state;
  state_t            state_d;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W:0]   len;
  logic [CNT_W-1:0]  step_cnt;
  logic              accept;
  logic              beat_last;
  logic [ADDR_W-1:0] idx [NUM_COLS];
  logic [ROW_W-1:0]  col [NUM_COLS];
  logic [ROW_W-1:0]  win [NUM_COLS];

  // clear blocks the write so a beat offered alongside it is never taken.
  assign wr_ready  = (state != ST_SHOW) && !clear;
  assign accept    = wr_valid && wr_ready;
  // The last free slot closes the message even without wr_last.
  assign beat_last = wr_last || (wr_ptr == PTR_LAST);

  // Window index chain starting at offset; short messages repeat circularly.
  always_comb begin
    idx[0] = offset;
    for (int k = 1; k < NUM_COLS; k++) begin
      idx[k] = wrap_inc(idx[k-1], len);
    end
  end

  led_col_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk12MHz (clk12MHz),
    .we       (accept),
    .waddr    (wr_ptr),
    .wdata    (wr_data),
    .idx0     (idx[0]),
    .idx1     (idx[1]),
    .idx2     (idx[2]),
    .idx3     (idx[3]),
    .col0     (col[0]),
    .col1     (col[1]),
    .col2     (col[2]),
    .col3     (col[3])
  );

  // State register.
  always_ff @(posedge clk12MHz) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic: load until the final beat, then show until cleared.
  always_comb begin
    state_d = state;
    if (clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (accept) state_d = beat_last ? ST_SHOW : ST_LOAD;
        ST_LOAD: if (accept && beat_last) state_d = ST_SHOW;
        ST_SHOW: state_d = ST_SHOW;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Write pointer and message length; length latches on the closing beat.
  always_ff @(posedge clk12MHz) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      len    <= '0;
    end else if (accept) begin
      wr_ptr <= wr_ptr + ADDR_W'(1);
      if (beat_last) begin
        len <= {1'b0, wr_ptr} + (ADDR_W+1)'(1);
      end
    end
  end

  // Scroll timer and offset; held at zero outside SHOW, frozen while run is low.
  always_ff @(posedge clk12MHz) begin
    if (rst || clear || (state != ST_SHOW)) begin
      offset     <= '0;
      step_cnt   <= '0;
      wrap_pulse <= 1'b0;
    end else begin
      wrap_pulse <= 1'b0;
      if (run) begin
        if (step_cnt == CNT_LAST) begin
          step_cnt   <= '0;
          offset     <= wrap_inc(offset, len);
          wrap_pulse <= (wrap_inc(offset, len) == '0);
        end else begin
          step_cnt <= step_cnt + CNT_W'(1);
        end
      end
    end
  end

  // Registered window; blank whenever not showing.
  always_ff @(posedge clk12MHz) begin
    for (int k = 0; k < NUM_COLS; k++) begin
      if (rst || clear || (state != ST_SHOW)) begin
        win[k] <= '0;
      end else begin
        win[k] <= col[k];
      end
    end
  end

  // Display-active flag, aligned with the registered window.
  always_ff @(posedge clk12MHz) begin
    if (rst) begin
      showing <= 1'b0;
    end else begin
      showing <= (state == ST_SHOW);
    end
  end

  assign l1 = win[0];
  assign l2 = win[1];
  assign l3 = win[2];
  assign l4 = win[3];

endmodule

// File: tb/tb_led_scroll_buffer.sv
// Bench for led_scroll_buffer: directed scenarios plus random traffic,
// checked every cycle against a message-queue reference model.
module tb_led_scroll_buffer;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int STEP   = 4;

  logic              clk12MHz = 1'b0;
  logic              rst      = 1'b1;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [7:0]        wr_data  = 8'h00;
  logic              wr_last  = 1'b0;
  logic              clear    = 1'b0;
  logic              run      = 1'b1;
  logic [7:0]        l1, l2, l3, l4;
  logic [ADDR_W-1:0] offset;
  logic              wrap_pulse;
  logic              showing;

  always #5 clk12MHz = ~clk12MHz;

  led_scroll_buffer #(
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .STEP_DIV (STEP)
  ) dut (
    .clk12MHz   (clk12MHz),
    .rst        (rst),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .wr_last    (wr_last),
    .clear      (clear),
    .run        (run),
    .l1         (l1),
    .l2         (l2),
    .l3         (l3),
    .l4         (l4),
    .offset     (offset),
    .wrap_pulse (wrap_pulse),
    .showing    (showing)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: 0 empty, 1 loading, 2 showing.
  int          m_st   = 0;
  byte unsigned m_msg[$];
  int          m_off  = 0;
  int          m_cnt  = 0;
  logic [7:0]  m_win[4] = '{default: 8'h00};
  bit          m_wrap = 1'b0;
  bit          m_show = 1'b0;
  bit          known  = 1'b0;
  int          acc_cnt = 0;

  // One clock: check handshake, advance the model across the edge, check outputs.
  task automatic tick();
    bit         i_rst, i_clr, i_val, i_last, i_run;
    logic [7:0] i_dat;
    int         n;
    #1;
    if (known) check("wr_ready", wr_ready, ((m_st != 2) && !clear));
    i_rst = rst; i_clr = clear; i_val = wr_valid; i_last = wr_last;
    i_run = run; i_dat = wr_data;
    if (i_val && wr_ready === 1'b1) acc_cnt++;
    @(posedge clk12MHz);
    if (i_rst) begin
      m_st = 0; m_msg.delete(); m_off = 0; m_cnt = 0;
      m_win = '{default: 8'h00}; m_wrap = 1'b0; m_show = 1'b0;
      known = 1'b1;
    end else begin
      n = m_msg.size();
      m_show = (m_st == 2);
      for (int k = 0; k < 4; k++) begin
        m_win[k] = 8'h00;
        if (!i_clr && m_st == 2) m_win[k] = m_msg[(m_off + k) % n];
      end
      m_wrap = 1'b0;
      if (i_clr) begin
        m_st = 0; m_msg.delete(); m_off = 0; m_cnt = 0;
      end else if (m_st == 2) begin
        if (i_run) begin
          if (m_cnt == STEP - 1) begin
            m_cnt  = 0;
            m_off  = (m_off + 1) % n;
            m_wrap = (m_off == 0);
          end else begin
            m_cnt++;
          end
        end
      end else if (i_val) begin
        m_msg.push_back(i_dat);
        if (i_last || m_msg.size() == DEPTH) begin
          m_st = 2; m_off = 0; m_cnt = 0;
        end else begin
          m_st = 1;
        end
      end
    end
    #2;
    if (known) begin
      check("l1", l1, m_win[0]);
      check("l2", l2, m_win[1]);
      check("l3", l3, m_win[2]);
      check("l4", l4, m_win[3]);
      check("offset", offset, m_off);
      check("wrap_pulse", wrap_pulse, m_wrap);
      check("showing", showing, m_show);
    end
  endtask

  task automatic send(input logic [7:0] d, input bit last);
    wr_valid = 1'b1; wr_data = d; wr_last = last;
    tick();
    wr_valid = 1'b0; wr_last = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    int wraps;
    int first_wrap;
    int b;

    // Reset, then the six-column walking-bit message.
    rst = 1'b1; run = 1'b1;
    tick(); tick();
    rst = 1'b0;
    send(8'h01, 0); send(8'h02, 0); send(8'h04, 0);
    send(8'h08, 0); send(8'h10, 0); send(8'h20, 1);
    wraps = 0; first_wrap = -1;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (wrap_pulse === 1'b1) begin
        wraps++;
        if (first_wrap < 0) first_wrap = n;
      end
      if (n == 1)  check("s1_first_window", {l1, l2, l3, l4}, 32'h01020408);
      if (n == 5)  check("s1_offset1_window", {l1, l2, l3, l4}, 32'h02040810);
      if (n == 22) check("s1_offset5_window", {l1, l2, l3, l4}, 32'h20010204);
    end
    check("s1_wrap_count", wraps, 1);
    check("s1_wrap_cycle", first_wrap, 24);

    // Two-column message repeats inside the window.
    do_clear();
    send(8'hAA, 0); send(8'h55, 1);
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (n == 1) check("s2_first_window", {l1, l2, l3, l4}, 32'hAA55AA55);
      if (n == 5) check("s2_step_window", {l1, l2, l3, l4}, 32'h55AA55AA);
      if (n == 8) check("s2_wrap", wrap_pulse, 1);
    end

    // Overlong stream without wr_last: only DEPTH beats are taken.
    do_clear();
    acc_cnt = 0;
    wr_valid = 1'b1; wr_last = 1'b0;
    for (int i = 0; i < 20; i++) begin
      wr_data = 8'($urandom);
      tick();
    end
    wr_valid = 1'b0;
    check("s3_accepted", acc_cnt, DEPTH);
    check("s3_showing", showing, 1);

    // Freeze mid-count, then resume.
    for (int i = 0; i < 6; i++) tick();
    run = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    run = 1'b1;
    for (int i = 0; i < 12; i++) tick();

    // clear with a simultaneous beat during LOAD.
    do_clear();
    send(8'h71, 0); send(8'h72, 0); send(8'h73, 0);
    clear = 1'b1; wr_valid = 1'b1; wr_data = 8'hEE;
    tick();
    clear = 1'b0; wr_valid = 1'b0;
    check("s5_blank", {l1, l2, l3, l4}, 32'h0);
    send(8'h11, 0); send(8'h22, 1);
    tick();
    check("s5_reload_window", {l1, l2, l3, l4}, 32'h11221122);

    // Reset while showing at offset 3.
    do_clear();
    for (int i = 0; i < 8; i++) send(8'(3 * (i + 1)), (i == 7));
    b = 0;
    while (offset !== 3 && b < 100) begin
      tick();
      b++;
    end
    check("s6_reach_offset3", (b < 100), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("s6_blank", {l1, l2, l3, l4}, 32'h0);
    check("s6_showing", showing, 0);
    check("s6_ready", wr_ready, 1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 199) == 0);
      clear    = ($urandom_range(0, 49) == 0);
      wr_valid = $urandom_range(0, 1) == 1;
      wr_last  = ($urandom_range(0, 7) == 0);
      wr_data  = 8'($urandom);
      run      = ($urandom_range(0, 7) != 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
